mc_ctrl_fsm: RTL and testbench

- Multicycle control FSM that sequences the single shared ALU, register file and unified instruction/data memory for the MIPS-subset core.
- Consumes opcode/funct from the decode stage. Decode re-latches from the instruction register on the falling clock edge.
- Emits per-cycle datapath control and a memory request/ready handshake.
- One instruction completes every 3–5 states plus any memory wait cycles.

---
 rtl/mc_ctrl_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS-subset control FSM with memory request/ready handshake
// Optional MC_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module mc_ctrl_fsm #(
   parameter int PC_INC = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [5:0]  i_opcode,
   input  logic [5:0]  i_funct,
   input  logic        i_alu_zero,
   input  logic        i_mem_ready,
   output logic        o_mem_rd,
   output logic        o_mem_wr,
   output logic        o_iord,
   output logic        o_ir_we,
   output logic        o_pc_we,
   output logic [1:0]  o_pc_src,
   output logic        o_alu_src_a,
   output logic [1:0]  o_alu_src_b,
   output logic [3:0]  o_alu_ctrl,
   output logic        o_reg_we,
   output logic        o_reg_dst,
   output logic        o_mem_to_reg,
   output logic        o_instr_done,
   output logic        o_illegal
`ifdef MC_PERF_CNT_EN
   ,
   output logic [31:0] o_cycle_cnt,
   output logic [31:0] o_instr_cnt
`endif
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;

   // alu_src_b=1 hard-wires the PC increment in the datapath; only word fetch is supported.
   if (PC_INC != 4) begin : g_pc_inc_chk
      $error("mc_ctrl_fsm supports PC_INC == 4 only");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JUMP_REG, S_TRAP
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_r_funct_ok;

   assign w_r_funct_ok = (i_funct == 6'h20) || (i_funct == 6'h22) || (i_funct == 6'h24) ||
                         (i_funct == 6'h25) || (i_funct == 6'h2A) || (i_funct == 6'h00);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      o_mem_rd     = 1'b0;
      o_mem_wr     = 1'b0;
      o_iord       = 1'b0;
      o_ir_we      = 1'b0;
      o_pc_we      = 1'b0;
      o_pc_src     = 2'd0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = 2'd0;
      o_alu_ctrl   = ALU_AND;
      o_reg_we     = 1'b0;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_instr_done = 1'b0;
      o_illegal    = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            o_mem_rd    = 1'b1;
            o_alu_src_b = 2'd1;
            o_alu_ctrl  = ALU_ADD;
            if (i_mem_ready) begin
               o_ir_we = 1'b1;
               o_pc_we = 1'b1;
               w_next  = S_DECODE;
            end
         end
         S_DECODE: begin
            o_alu_src_b = 2'd3;
            o_alu_ctrl  = ALU_ADD;
            case (i_opcode)
               OP_LW, OP_SW:     w_next = S_MEM_ADDR;
               OP_RTYPE: begin
                  if (w_r_funct_ok)           w_next = S_R_EXEC;
                  else if (i_funct == 6'h08)  w_next = S_JUMP_REG;
                  else                        w_next = S_TRAP;
               end
               OP_BEQ, OP_BNE:   w_next = S_BRANCH;
               OP_ADDI, OP_ORI:  w_next = S_I_EXEC;
               OP_J:             w_next = S_JUMP;
               default:          w_next = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'd2;
            o_alu_ctrl  = ALU_ADD;
            w_next      = (i_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            o_mem_rd = 1'b1;
            o_iord   = 1'b1;
            if (i_mem_ready) w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            o_reg_we     = 1'b1;
            o_mem_to_reg = 1'b1;
            o_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEM_WRITE: begin
            o_mem_wr = 1'b1;
            o_iord   = 1'b1;
            if (i_mem_ready) begin
               o_instr_done = 1'b1;
               w_next       = S_FETCH;
            end
         end
         S_R_EXEC: begin
            o_alu_src_a = 1'b1;
            case (i_funct)
               6'h22:   o_alu_ctrl = ALU_SUB;
               6'h24:   o_alu_ctrl = ALU_AND;
               6'h25:   o_alu_ctrl = ALU_OR;
               6'h2A:   o_alu_ctrl = ALU_SLT;
               6'h00:   o_alu_ctrl = ALU_SLL;
               default: o_alu_ctrl = ALU_ADD;
            endcase
            w_next = S_R_WB;
         end
         S_R_WB: begin
            o_reg_we     = 1'b1;
            o_reg_dst    = 1'b1;
            o_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_I_EXEC: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'd2;
            o_alu_ctrl  = (i_opcode == OP_ORI) ? ALU_OR : ALU_ADD;
            w_next      = S_I_WB;
         end
         S_I_WB: begin
            o_reg_we     = 1'b1;
            o_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_BRANCH: begin
            o_alu_src_a  = 1'b1;
            o_alu_ctrl   = ALU_SUB;
            o_pc_src     = 2'd1;
            o_pc_we      = (i_opcode == OP_BNE) ? ~i_alu_zero : i_alu_zero;
            o_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_JUMP: begin
            o_pc_we      = 1'b1;
            o_pc_src     = 2'd2;
            o_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_JUMP_REG: begin
            o_pc_we      = 1'b1;
            o_pc_src     = 2'd3;
            o_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_TRAP: o_illegal = 1'b1;
         default: w_next = S_IDLE;
      endcase
   end

`ifdef MC_PERF_CNT_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cycle_cnt <= 32'd0;
         r_instr_cnt <= 32'd0;
      end else begin
         if (r_state != S_IDLE && r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (o_instr_done) r_instr_cnt <= r_instr_cnt + 32'd1;
      end
   end

   assign o_cycle_cnt = r_cycle_cnt;
   assign o_instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - randomized instruction-level check of mc_ctrl_fsm against a per-instruction cycle plan
module tb_mc_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic        alu_zero, mem_ready;
   logic        mem_rd, mem_wr, iord, ir_we, pc_we, alu_src_a;
   logic [1:0]  pc_src, alu_src_b;
   logic [3:0]  alu_ctrl;
   logic        reg_we, reg_dst, mem_to_reg, instr_done, illegal;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.PC_INC(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct(funct),
      .i_alu_zero(alu_zero), .i_mem_ready(mem_ready),
      .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_iord(iord), .o_ir_we(ir_we),
      .o_pc_we(pc_we), .o_pc_src(pc_src), .o_alu_src_a(alu_src_a),
      .o_alu_src_b(alu_src_b), .o_alu_ctrl(alu_ctrl), .o_reg_we(reg_we),
      .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_instr_done(instr_done),
      .o_illegal(illegal)
`ifdef MC_PERF_CNT_EN
      , .o_cycle_cnt(cycle_cnt), .o_instr_cnt(instr_cnt)
`endif
   );

   // Control word: {rd,wr,iord,ir_we,pc_we,pc_src[1:0],src_a,src_b[1:0],alu[3:0],reg_we,reg_dst,m2r,done,illegal}
   logic [18:0] obs;
   assign obs = {mem_rd, mem_wr, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                 alu_ctrl, reg_we, reg_dst, mem_to_reg, instr_done, illegal};

   localparam logic [18:0] RD   = 19'h40000, WR  = 19'h20000, IORD = 19'h10000;
   localparam logic [18:0] IRWE = 19'h08000, PCWE = 19'h04000;
   localparam logic [18:0] RWE  = 19'h00010, RDST = 19'h00008, M2R = 19'h00004;
   localparam logic [18:0] DONE = 19'h00002, ILL = 19'h00001;
   localparam logic [3:0]  A_AND = 4'h0, A_OR = 4'h1, A_ADD = 4'h2, A_SUB = 4'h6, A_SLT = 4'h7, A_SLL = 4'h8;

   typedef struct {
      logic [18:0] w;
      logic        rdy;
   } step_t;

   step_t plan[$];
   int    checks = 0;
   int    errors = 0;
   int    exp_cyc = 0;
   int    exp_ins = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [18:0] dp(input logic [1:0] psrc, input logic sa, input logic [1:0] sb, input logic [3:0] alu);
      logic [18:0] w;
      w = 19'd0;
      w[13:12] = psrc;
      w[11]    = sa;
      w[10:9]  = sb;
      w[8:5]   = alu;
      return w;
   endfunction

   task automatic add_step(input logic [18:0] w, input logic rdy);
      step_t s;
      s.w = w;
      s.rdy = rdy;
      plan.push_back(s);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected cycle-by-cycle control for one whole instruction, including memory wait states.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fw, input int mw);
      logic [3:0] alu;
      plan.delete();
      for (int i = 0; i < fw; i++) add_step(RD | dp(2'd0, 1'b0, 2'd1, A_ADD), 1'b0);
      add_step(RD | IRWE | PCWE | dp(2'd0, 1'b0, 2'd1, A_ADD), 1'b1);
      add_step(dp(2'd0, 1'b0, 2'd3, A_ADD), rnd_bit());
      if (op == 6'h23 || op == 6'h2B) begin
         add_step(dp(2'd0, 1'b1, 2'd2, A_ADD), rnd_bit());
         if (op == 6'h23) begin
            for (int i = 0; i < mw; i++) add_step(RD | IORD, 1'b0);
            add_step(RD | IORD, 1'b1);
            add_step(RWE | M2R | DONE, rnd_bit());
         end else begin
            for (int i = 0; i < mw; i++) add_step(WR | IORD, 1'b0);
            add_step(WR | IORD | DONE, 1'b1);
         end
      end else if (op == 6'h00 && fn == 6'h08) begin
         add_step(PCWE | dp(2'd3, 1'b0, 2'd0, 4'h0) | DONE, rnd_bit());
      end else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A || fn == 6'h00)) begin
         alu = (fn == 6'h20) ? A_ADD : (fn == 6'h22) ? A_SUB : (fn == 6'h24) ? A_AND :
               (fn == 6'h25) ? A_OR  : (fn == 6'h2A) ? A_SLT : A_SLL;
         add_step(dp(2'd0, 1'b1, 2'd0, alu), rnd_bit());
         add_step(RWE | RDST | DONE, rnd_bit());
      end else if (op == 6'h04 || op == 6'h05) begin
         add_step(((z ^ (op == 6'h05)) ? PCWE : 19'd0) | dp(2'd1, 1'b1, 2'd0, A_SUB) | DONE, rnd_bit());
      end else if (op == 6'h08 || op == 6'h0D) begin
         add_step(dp(2'd0, 1'b1, 2'd2, (op == 6'h0D) ? A_OR : A_ADD), rnd_bit());
         add_step(RWE | DONE, rnd_bit());
      end else if (op == 6'h02) begin
         add_step(PCWE | dp(2'd2, 1'b0, 2'd0, 4'h0) | DONE, rnd_bit());
      end else begin
         for (int i = 0; i < 100; i++) add_step(ILL, rnd_bit());
      end
   endtask

   // Entered and left at posedge+1; outputs checked at posedge+2.
   task automatic run_plan(input string tag);
      foreach (plan[i]) begin
         mem_ready = plan[i].rdy;
         #1;
         check(tag, 32'(obs), 32'(plan[i].w));
         @(posedge clk);
         #1;
         if (plan[i].w[0] == 1'b0) exp_cyc++;
         if (plan[i].w[1]) exp_ins++;
      end
`ifdef MC_PERF_CNT_EN
      check({tag, "_cyc"}, cycle_cnt, 32'(exp_cyc));
      check({tag, "_ins"}, instr_cnt, 32'(exp_ins));
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_async", 32'(obs), 32'd0);
      @(posedge clk);
      #1;
      exp_cyc = 0;
      exp_ins = 0;
      check("rst_hold", 32'(obs), 32'd0);
      rst = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("idle", 32'(obs), 32'd0);
`ifdef MC_PERF_CNT_EN
      check("rst_cyc", cycle_cnt, 32'd0);
      check("rst_ins", instr_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fw, input int mw);
      opcode = op;
      funct = fn;
      alu_zero = z;
      build(op, fn, z, fw, mw);
      run_plan(tag);
   endtask

   logic [5:0] ops[10]  = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h00};
   logic [5:0] rfns[6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

   initial begin
      rst = 1'b1;
      opcode = 6'h00;
      funct = 6'h20;
      alu_zero = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
      run_instr("lw_wait", 6'h23, 6'h00, 1'b0, 3, 3);
      run_instr("beq_t", 6'h04, 6'h00, 1'b1, 0, 0);
      run_instr("beq_n", 6'h04, 6'h00, 1'b0, 1, 0);
      run_instr("bne_t", 6'h05, 6'h00, 1'b0, 0, 0);
      run_instr("bne_n", 6'h05, 6'h00, 1'b1, 0, 0);
      run_instr("jr", 6'h00, 6'h08, 1'b0, 2, 0);

      for (int n = 0; n < 60; n++) begin
         int k;
         logic [5:0] fn;
         k  = $urandom_range(0, 9);
         fn = (k == 9) ? 6'h08 : rfns[$urandom_range(0, 5)];
         run_instr("rand", ops[k], fn, rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      run_instr("trap", 6'h3F, 6'h00, 1'b0, 1, 0);
      do_reset();
      run_instr("trap_rfn", 6'h00, 6'h3F, 1'b1, 0, 0);
      do_reset();

      opcode = 6'h2B;
      funct = 6'h00;
      plan.delete();
      add_step(RD | IRWE | PCWE | dp(2'd0, 1'b0, 2'd1, A_ADD), 1'b1);
      add_step(dp(2'd0, 1'b0, 2'd3, A_ADD), 1'b1);
      add_step(dp(2'd0, 1'b1, 2'd2, A_ADD), 1'b1);
      add_step(WR | IORD, 1'b0);
      add_step(WR | IORD, 1'b0);
      run_plan("sw_wait");
      mem_ready = 1'b0;
      #1;
      check("sw_wait_pre", 32'(obs), 32'(WR | IORD));
      do_reset();
      run_instr("post_rst", 6'h0D, 6'h00, 1'b0, 0, 0);

`ifdef MC_PERF_CNT_EN
      do_reset();
      for (int n = 0; n < 10; n++) run_instr("perf_add", 6'h00, 6'h20, 1'b0, 0, 0);
      check("perf_cyc40", cycle_cnt, 32'd40);
      check("perf_ins10", instr_cnt, 32'd10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
